// File: rtl/ritc_align_pkg.sv
// Shared definitions for the RITC auto-alignment bus master.
// Register map, field positions, FSM states and bus word builders.
package ritc_align_pkg;

  localparam logic [3:0] DPTRAINING = 4'd2;
  localparam logic [3:0] DPIDELAY   = 4'd4;

  localparam int TRAIN_DISABLE = 31;
  localparam int BITSLIP       = 30;
  localparam int SEL_LSB       = 16;
  localparam int LOAD          = 31;

  localparam int NUM_CH   = 6;
  localparam int NUM_BIT  = 12;
  localparam int NUM_BITS = NUM_CH * NUM_BIT;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEL,
    S_SET_DLY,
    S_SETTLE,
    S_READ,
    S_EVAL,
    S_CENTER,
    S_SETTLE2,
    S_READ2,
    S_CHECK,
    S_NEXT,
    S_FINISH
  } state_e;

  // True when pat is any circular rotation of train.
  function automatic logic is_rotation(
    input logic [7:0] pat,
    input logic [7:0] train
  );
    logic       hit;
    logic [7:0] rot;
    hit = 1'b0;
    rot = train;
    for (int i = 0; i < 8; i++) begin
      if (pat == rot) hit = 1'b1;
      rot = {rot[6:0], rot[7]};
    end
    return hit;
  endfunction

  function automatic logic [31:0] train_word(
    input logic       dis,
    input logic       slip,
    input logic [6:0] sel
  );
    logic [31:0] w;
    w = '0;
    w[TRAIN_DISABLE] = dis;
    w[BITSLIP] = slip;
    w[SEL_LSB +: 7] = sel;
    return w;
  endfunction

  function automatic logic [31:0] idelay_word(
    input logic [6:0] sel,
    input logic [4:0] dly
  );
    logic [31:0] w;
    w = '0;
    w[LOAD] = 1'b1;
    w[SEL_LSB +: 7] = sel;
    w[4:0] = dly;
    return w;
  endfunction

endpackage

// File: rtl/ritc_auto_align_ritc_eye_tracker.sv
// Longest-passing-run tracker over a 32-tap IDELAY sweep.
// Ties keep the earliest run; runs never wrap from tap 31 to 0.
module ritc_eye_tracker (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [4:0] tap_i,
  input  logic       pass_i,
  output logic [4:0] best_start_o,
  output logic [5:0] best_len_o
);

  logic [4:0] cur_start_q;
  logic [5:0] cur_len_q;
  logic [4:0] best_start_q;
  logic [5:0] best_len_q;
  logic [4:0] run_start_d;
  logic [5:0] run_len_d;

  // Extend the current run with this tap, or start one here.
  always_comb begin
    run_start_d = (cur_len_q == 6'd0) ? tap_i : cur_start_q;
    run_len_d   = cur_len_q + 6'd1;
  end

  // Update the current run and promote it when strictly longer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else if (clr_i) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else if (en_i) begin
      if (pass_i) begin
        cur_start_q <= run_start_d;
        cur_len_q   <= run_len_d;
        if (run_len_d > best_len_q) begin
          best_start_q <= run_start_d;
          best_len_q   <= run_len_d;
        end
      end else begin
        cur_len_q <= '0;
      end
    end
  end

  assign best_start_o = best_start_q;
  assign best_len_o   = best_len_q;

endmodule

// File: rtl/ritc_auto_align.sv
// Trains all 72 RITC data bits: IDELAY eye sweep, centre load, bitslip.
// Optional eye-width log enabled by defining RITC_ALIGN_EYE_LOG_EN.
module ritc_auto_align
  import ritc_align_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = 8'hA6,
  parameter int         SETTLE_CYCLES = 64,
  parameter int         MIN_EYE       = 4,
  parameter int         MAX_BITSLIP   = 8
) (
  input  logic        user_clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        dp_sel_o,
  output logic        dp_wr_o,
  output logic [3:0]  dp_addr_o,
  output logic [31:0] dp_dat_o,
  input  logic [31:0] dp_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [6:0]  cur_bit_o,
  output logic [71:0] fail_map_o,
  input  logic [6:0]  eye_addr_i,
  output logic [5:0]  eye_width_o
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES);

  state_e      state_q;
  logic        dp_sel_q;
  logic        dp_wr_q;
  logic [3:0]  dp_addr_q;
  logic [31:0] dp_dat_q;
  logic        busy_q;
  logic        done_q;
  logic [2:0]  ch_q;
  logic [3:0]  bit_q;
  logic [6:0]  idx_q;
  logic [71:0] fail_q;
  logic [4:0]  tap_q;
  logic [15:0] cnt_q;
  logic [3:0]  slip_q;
  logic [7:0]  pat_q;

  logic [6:0]  sel;
  logic        pass_d;
  logic [4:0]  best_start;
  logic [5:0]  best_len;
  logic [4:0]  center_d;
  logic        unused_dat;

  assign sel        = {ch_q, bit_q};
  assign pass_d     = is_rotation(pat_q, TRAIN_PATTERN);
  assign center_d   = best_start + best_len[5:1];
  assign unused_dat = ^dp_dat_i[31:8];

  ritc_eye_tracker u_eye (
    .clk_i        (user_clk_i),
    .rst_i        (rst_i),
    .clr_i        (state_q == S_SEL),
    .en_i         (state_q == S_EVAL),
    .tap_i        (tap_q),
    .pass_i       (pass_d),
    .best_start_o (best_start),
    .best_len_o   (best_len)
  );

  // Alignment FSM; each bus access is issued here and shows next cycle.
  always_ff @(posedge user_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      dp_sel_q  <= 1'b0;
      dp_wr_q   <= 1'b0;
      dp_addr_q <= '0;
      dp_dat_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ch_q      <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      fail_q    <= '0;
      tap_q     <= '0;
      cnt_q     <= '0;
      slip_q    <= '0;
      pat_q     <= '0;
    end else begin
      dp_sel_q  <= 1'b0;
      dp_wr_q   <= 1'b0;
      dp_addr_q <= '0;
      dp_dat_q  <= '0;
      done_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            fail_q  <= '0;
            busy_q  <= 1'b1;
            ch_q    <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            state_q <= S_SEL;
          end
        end
        S_SEL: begin
          dp_sel_q  <= 1'b1;
          dp_wr_q   <= 1'b1;
          dp_addr_q <= DPTRAINING;
          dp_dat_q  <= train_word(1'b0, 1'b0, sel);
          tap_q     <= '0;
          state_q   <= S_SET_DLY;
        end
        S_SET_DLY: begin
          // Leave an idle bus cycle after the select write.
          if (!dp_sel_q) begin
            dp_sel_q  <= 1'b1;
            dp_wr_q   <= 1'b1;
            dp_addr_q <= DPIDELAY;
            dp_dat_q  <= idelay_word(sel, tap_q);
            cnt_q     <= '0;
            state_q   <= S_SETTLE;
          end
        end
        S_SETTLE, S_SETTLE2: begin
          if (cnt_q == SETTLE_LAST) begin
            dp_sel_q  <= 1'b1;
            dp_addr_q <= DPTRAINING;
            state_q   <= (state_q == S_SETTLE) ? S_READ : S_READ2;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_READ: begin
          pat_q   <= dp_dat_i[7:0];
          state_q <= S_EVAL;
        end
        S_EVAL: begin
          if (tap_q != 5'd31) begin
            tap_q   <= tap_q + 5'd1;
            state_q <= S_SET_DLY;
          end else begin
            state_q <= S_CENTER;
          end
        end
        S_CENTER: begin
          dp_sel_q  <= 1'b1;
          dp_wr_q   <= 1'b1;
          dp_addr_q <= DPIDELAY;
          if (best_len < 6'(MIN_EYE)) begin
            fail_q[idx_q] <= 1'b1;
            dp_dat_q      <= idelay_word(sel, 5'd0);
            state_q       <= S_NEXT;
          end else begin
            dp_dat_q <= idelay_word(sel, center_d);
            slip_q   <= '0;
            cnt_q    <= '0;
            state_q  <= S_SETTLE2;
          end
        end
        S_READ2: begin
          pat_q   <= dp_dat_i[7:0];
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (pat_q == TRAIN_PATTERN) begin
            state_q <= S_NEXT;
          end else if (slip_q == 4'(MAX_BITSLIP)) begin
            fail_q[idx_q] <= 1'b1;
            state_q       <= S_NEXT;
          end else begin
            dp_sel_q  <= 1'b1;
            dp_wr_q   <= 1'b1;
            dp_addr_q <= DPTRAINING;
            dp_dat_q  <= train_word(1'b0, 1'b1, sel);
            slip_q    <= slip_q + 4'd1;
            cnt_q     <= '0;
            state_q   <= S_SETTLE2;
          end
        end
        S_NEXT: begin
          idx_q <= idx_q + 7'd1;
          if (bit_q == 4'(NUM_BIT - 1)) begin
            if (ch_q == 3'(NUM_CH - 1)) begin
              state_q <= S_FINISH;
            end else begin
              ch_q    <= ch_q + 3'd1;
              bit_q   <= '0;
              state_q <= S_SEL;
            end
          end else begin
            bit_q   <= bit_q + 4'd1;
            state_q <= S_SEL;
          end
        end
        S_FINISH: begin
          dp_sel_q  <= 1'b1;
          dp_wr_q   <= 1'b1;
          dp_addr_q <= DPTRAINING;
          dp_dat_q  <= train_word(1'b1, 1'b0, sel);
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dp_sel_o   = dp_sel_q;
  assign dp_wr_o    = dp_wr_q;
  assign dp_addr_o  = dp_addr_q;
  assign dp_dat_o   = dp_dat_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cur_bit_o  = sel;
  assign fail_map_o = fail_q;

`ifdef RITC_ALIGN_EYE_LOG_EN
  logic [5:0] eye_q [NUM_BITS];
  logic [5:0] eye_rd_q;
  logic [6:0] ea_idx;
  logic       ea_ok;

  assign ea_idx = 7'(eye_addr_i[6:4]) * 7'd12 + 7'(eye_addr_i[3:0]);
  assign ea_ok  = (eye_addr_i[6:4] < 3'(NUM_CH)) &&
                  (eye_addr_i[3:0] < 4'(NUM_BIT));

  // Log best run length per bit and serve registered reads.
  always_ff @(posedge user_clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_BITS; i++) eye_q[i] <= '0;
      eye_rd_q <= '0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        for (int i = 0; i < NUM_BITS; i++) eye_q[i] <= '0;
      end else if (state_q == S_CENTER) begin
        eye_q[idx_q] <= best_len;
      end
      eye_rd_q <= ea_ok ? eye_q[ea_idx] : 6'd0;
    end
  end

  assign eye_width_o = eye_rd_q;
`else
  logic unused_eye;
  assign unused_eye  = ^eye_addr_i;
  assign eye_width_o = '0;
`endif

endmodule

// File: tb/tb_ritc_auto_align.sv
// Directed bench for ritc_auto_align against a behavioural datapath.
// Per-bit eye windows, bitslip offsets and stuck bits drive the scenarios.
module tb_ritc_auto_align;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        dp_sel;
  logic        dp_wr;
  logic [3:0]  dp_addr;
  logic [31:0] dp_dat;
  logic [31:0] dp_dat_in;
  logic        busy;
  logic        done;
  logic [6:0]  cur_bit;
  logic [71:0] fail_map;
  logic [6:0]  eye_addr = 7'h00;
  logic [5:0]  eye_width;

  int checks = 0;
  int errors = 0;

  // Datapath model configuration (written by the stimulus only).
  logic [4:0] lo [72];
  logic [4:0] hi [72];
  logic [4:0] lo2 [72];
  logic [4:0] hi2 [72];
  logic [2:0] rot0 [72];
  logic       stuck [72];

  // Datapath model state (written by the model only).
  logic        model_clr = 1'b0;
  logic [6:0]  cur_sel = 7'h00;
  logic [4:0]  dly [72];
  int          slips [72];
  int          n_wr, n_dly, n_slip, done_cnt, viol;
  logic [3:0]  last_addr;
  logic [31:0] last_dat;
  logic        prev_sel;
  int          mk;
  logic [4:0]  md;

  always #5 clk = ~clk;

  ritc_auto_align #(.SETTLE_CYCLES(1)) dut (
    .user_clk_i  (clk),
    .rst_i       (rst),
    .start_i     (start),
    .dp_sel_o    (dp_sel),
    .dp_wr_o     (dp_wr),
    .dp_addr_o   (dp_addr),
    .dp_dat_o    (dp_dat),
    .dp_dat_i    (dp_dat_in),
    .busy_o      (busy),
    .done_o      (done),
    .cur_bit_o   (cur_bit),
    .fail_map_o  (fail_map),
    .eye_addr_i  (eye_addr),
    .eye_width_o (eye_width)
  );

  function automatic int sidx(input logic [6:0] s);
    if (s[6:4] < 3'd6 && s[3:0] < 4'd12) return int'(s[6:4]) * 12 + int'(s[3:0]);
    return 0;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < (n % 8); i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  always_comb begin
    mk = sidx(cur_sel);
    md = dly[mk];
    dp_dat_in = 32'h0;
    if (dp_addr == 4'd2 &&
        ((md >= lo[mk] && md <= hi[mk]) || (md >= lo2[mk] && md <= hi2[mk])))
      dp_dat_in = {24'h0, rotl(8'hA6, stuck[mk] ? int'(rot0[mk])
                                                : int'(rot0[mk]) + slips[mk])};
  end

  always @(posedge clk) begin
    if (model_clr) begin
      n_wr <= 0; n_dly <= 0; n_slip <= 0; done_cnt <= 0; viol <= 0;
      last_addr <= 4'h0; last_dat <= 32'h0; prev_sel <= 1'b0;
      for (int i = 0; i < 72; i++) begin
        slips[i] <= 0;
        dly[i] <= 5'h1F;
      end
    end else begin
      prev_sel <= dp_sel;
      viol <= viol + ((dp_sel && prev_sel) ? 1 : 0)
                   + ((dp_sel && !dp_wr && dp_addr != 4'd2) ? 1 : 0);
      if (done) done_cnt <= done_cnt + 1;
      if (dp_sel && dp_wr) begin
        n_wr <= n_wr + 1;
        last_addr <= dp_addr;
        last_dat <= dp_dat;
        if (dp_addr == 4'd2) begin
          cur_sel <= dp_dat[22:16];
          if (dp_dat[30]) begin
            n_slip <= n_slip + 1;
            slips[sidx(dp_dat[22:16])] <= slips[sidx(dp_dat[22:16])] + 1;
          end
        end else if (dp_addr == 4'd4 && dp_dat[31]) begin
          n_dly <= n_dly + 1;
          dly[sidx(dp_dat[22:16])] <= dp_dat[4:0];
        end
      end
    end
  end

  task automatic set_defaults();
    for (int i = 0; i < 72; i++) begin
      lo[i] = 5'd10; hi[i] = 5'd20;
      lo2[i] = 5'd31; hi2[i] = 5'd0;
      rot0[i] = 3'd0; stuck[i] = 1'b0;
    end
  endtask

  task automatic clear_model();
    @(negedge clk); model_clr = 1'b1;
    @(negedge clk); model_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done_o=%b after %0d cycles, want 1", tag, done, n);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({dp_sel, dp_wr, dp_addr, dp_dat} !== 38'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h, want 0", {dp_sel, dp_wr, dp_addr, dp_dat});
    end
    checks++;
    if ({busy, done, cur_bit, fail_map, eye_width} !== 87'h0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b cur=%h fail=%h eye=%h, want 0",
               busy, done, cur_bit, fail_map, eye_width);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_pass();
    int bad;
    logic [6:0] cb;
    set_defaults();
    clear_model();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || cur_bit !== 7'h00) begin
      errors++;
      $display("FAIL start_busy: busy=%b cur=%h, want 1 00", busy, cur_bit);
    end
    repeat (3000) @(negedge clk);
    cb = cur_bit;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || cur_bit == 7'h00 || cur_bit < cb) begin
      errors++;
      $display("FAIL start_ignored: cur=%h before=%h busy=%b, want no restart",
               cur_bit, cb, busy);
    end
    wait_done("all_pass");
    bad = 0;
    for (int i = 0; i < 72; i++) if (dly[i] !== 5'd15 || slips[i] != 0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL all_pass_delay: %0d bits not at delay 15/no slip, want 0", bad);
    end
    checks++;
    if (fail_map !== 72'h0) begin
      errors++;
      $display("FAIL all_pass_map: got %h, want 0", fail_map);
    end
    checks++;
    if (n_slip != 0 || n_dly != 2376) begin
      errors++;
      $display("FAIL all_pass_counts: slips=%0d dly_wr=%0d, want 0 2376", n_slip, n_dly);
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL all_pass_pulse: done_cnt=%0d busy=%b, want 1 0", done_cnt, busy);
    end
    checks++;
    if (last_addr !== 4'd2 || last_dat !== 32'h805B_0000) begin
      errors++;
      $display("FAIL last_write: addr=%0d dat=%h, want 2 805b0000", last_addr, last_dat);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL bus_rules: %0d violations, want 0", viol);
    end
  endtask

  task automatic test_eye_log();
    logic [5:0] exp_w;
`ifdef RITC_ALIGN_EYE_LOG_EN
    exp_w = 6'd11;
`else
    exp_w = 6'd0;
`endif
    @(negedge clk); eye_addr = 7'h13;
    @(posedge clk); #1;
    checks++;
    if (eye_width !== exp_w) begin
      errors++;
      $display("FAIL eye_13: got %0d, want %0d", eye_width, exp_w);
    end
    @(negedge clk); eye_addr = 7'h0C;
    @(posedge clk); #1;
    checks++;
    if (eye_width !== 6'd0) begin
      errors++;
      $display("FAIL eye_0c: got %0d, want 0", eye_width);
    end
    @(negedge clk); eye_addr = 7'h60;
    @(posedge clk); #1;
    checks++;
    if (eye_width !== 6'd0) begin
      errors++;
      $display("FAIL eye_60: got %0d, want 0", eye_width);
    end
  endtask

  task automatic test_corner_bits();
    int bad;
    set_defaults();
    lo[0] = 5'd2; hi[0] = 5'd6; lo2[0] = 5'd20; hi2[0] = 5'd24;
    rot0[1] = 3'd5;
    rot0[2] = 3'd1; stuck[2] = 1'b1;
    lo[29] = 5'd3; hi[29] = 5'd5;
    clear_model();
    pulse_start();
    wait_done("corner");
    checks++;
    if (dly[0] !== 5'd4) begin
      errors++;
      $display("FAIL two_runs_delay: got %0d, want 4", dly[0]);
    end
    checks++;
    if (dly[29] !== 5'd0 || slips[29] != 0) begin
      errors++;
      $display("FAIL narrow_eye: dly=%0d slips=%0d, want 0 0", dly[29], slips[29]);
    end
    checks++;
    if (slips[1] != 3 || dly[1] !== 5'd15) begin
      errors++;
      $display("FAIL three_slips: slips=%0d dly=%0d, want 3 15", slips[1], dly[1]);
    end
    checks++;
    if (slips[2] != 8) begin
      errors++;
      $display("FAIL never_match: slips=%0d, want 8", slips[2]);
    end
    checks++;
    if (fail_map !== 72'h0000_0000_2000_0004) begin
      errors++;
      $display("FAIL corner_map: got %h, want 20000004", fail_map);
    end
    bad = 0;
    for (int i = 1; i < 72; i++) if (i != 29 && dly[i] !== 5'd15) bad++;
    checks++;
    if (bad != 0 || n_slip != 11) begin
      errors++;
      $display("FAIL corner_others: bad=%0d slips=%0d, want 0 11", bad, n_slip);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int nw;
    logic found;
    set_defaults();
    clear_model();
    pulse_start();
    n = 0;
    found = 1'b0;
    while (!found && n < 20000) begin
      @(posedge clk); #1;
      if (dp_sel && dp_wr && dp_addr == 4'd4 && dp_dat[22:16] == 7'h34) found = 1'b1;
      n++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_bit40: found=%b after %0d cycles, want 1", found, n);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({dp_sel, dp_wr, dp_addr, dp_dat, busy, done, cur_bit, fail_map} !== 119'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: bus=%h busy=%b cur=%h, want 0",
               {dp_sel, dp_wr, dp_addr, dp_dat}, busy, cur_bit);
    end
    nw = n_wr;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (n_wr != nw || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_quiet: writes %0d->%0d busy=%b, want none 0", nw, n_wr, busy);
    end
  endtask

  task automatic test_rerun();
    set_defaults();
    clear_model();
    pulse_start();
    @(posedge clk); #1;
    checks++;
    if (dp_sel !== 1'b1 || dp_wr !== 1'b1 || dp_addr !== 4'd2 ||
        dp_dat !== 32'h0 || cur_bit !== 7'h00) begin
      errors++;
      $display("FAIL rerun_first: sel=%b wr=%b addr=%0d dat=%h cur=%h, want 1 1 2 0 00",
               dp_sel, dp_wr, dp_addr, dp_dat, cur_bit);
    end
    wait_done("rerun");
    checks++;
    if (fail_map !== 72'h0 || dly[0] !== 5'd15 || dly[71] !== 5'd15 || done_cnt != 1) begin
      errors++;
      $display("FAIL rerun_result: map=%h d0=%0d d71=%0d done=%0d, want 0 15 15 1",
               fail_map, dly[0], dly[71], done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_eye_log();
    test_corner_bits();
    test_reset_mid_run();
    test_rerun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ritc_auto_align.md
Name: ritc_auto_align

Overview:
- Register-bus master that automatically trains all 72 RITC data bits (6 channels x 12 bits) of the dual-RITC datapath controller.
- It drives that controller's user register port and, per bit:
  - sweeps the data IDELAY and records the passing eye;
  - loads the eye centre;
  - bitslips until the training word matches exactly.
- It sits upstream of the datapath on the user_clk_i register bus, alongside the host bus mux.
- It finishes by disabling training and reporting a per-bit pass/fail map.

Parameters:
- TRAIN_PATTERN, 8'hA6, expected 8-bit training word (DPTRAINING[7:0]).
- SETTLE_CYCLES, 64, user_clk_i cycles to wait after any IDELAY load or bitslip before reading.
- MIN_EYE, 4, minimum passing-run length, in taps, for a bit to pass.
- MAX_BITSLIP, 8, bitslip attempts per bit before declaring slip failure.

Ports:
- user_clk_i  in  1  sole clock (register-bus clock).
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse; starts a full alignment run. Ignored while busy_o=1.
- dp_sel_o  out  1  bus select to datapath.
- dp_wr_o  out  1  bus write strobe.
- dp_addr_o  out  4  register address.
- dp_dat_o  out  32  write data.
- dp_dat_i  in  32  read data (combinational from dp_addr_o).
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at run end.
- cur_bit_o  out  7  bit select being processed, formatted {ch[2:0], bit[3:0]}.
- fail_map_o  out  72  bit index ch*12+bit is 1 if that bit failed (eye or slip).
- eye_addr_i  in  7  eye-log read select (optional feature).
- eye_width_o  out  6  eye-log read data (optional feature).

Behaviour:
Reset:
- All outputs 0; dp_* idle (sel=0, wr=0, addr=0, dat=0); state IDLE.
- Reset mid-run aborts immediately with no further bus writes. Datapath registers keep their last written values.

Bus rules:
- A write is a single cycle with sel=1, wr=1, addr and data valid.
- A read holds sel=1, wr=0, addr=2 for one cycle, and dp_dat_i is captured at the end of that cycle.
- Never more than one access per cycle. sel=0 between accesses.

Register targets:
- addr 2 (DPTRAINING): bit31 = train disable, bit30 = bitslip, [22:16] = bit select, [7:0] = read pattern.
- addr 4 (DPIDELAY): [4:0] = delay, [22:16] = select, bit31 = load.

State sequence:
- IDLE: on start_i, clear fail_map_o, set busy_o, set bit index to ch0/bit0 → SEL.
- SEL: write DPTRAINING = {0,0,...,sel,...}, i.e. training enabled, no slip. Clear the eye tracker and set tap=0 → SET_DLY.
- SET_DLY: write DPIDELAY = {1, sel, tap} → SETTLE.
- SETTLE: count SETTLE_CYCLES → READ.
- READ: read the pattern → EVAL.
- EVAL: a tap passes if the pattern equals any of the 8 circular rotations of TRAIN_PATTERN.
  - Run tracking: current run start and length, plus best start and length (6-bit length).
  - On a tie, the first (lowest-start) longest run is kept. No wrap from tap 31 to tap 0.
  - If tap<31: tap++ → SET_DLY. At tap 31 → CENTER.
- CENTER:
  - If best length < MIN_EYE: set the fail bit and load delay 0 → NEXT.
  - Otherwise load best_start + (best_len >> 1) (5-bit, cannot overflow), zero the slip count → SETTLE2.
- SETTLE2 and READ2: as SETTLE and READ.
- CHECK:
  - Pattern == TRAIN_PATTERN → NEXT.
  - Else if slip count == MAX_BITSLIP: set the fail bit → NEXT.
  - Else write DPTRAINING with bit30=1 and the same select, increment the slip count → SETTLE2.
- NEXT: bit++. After bit 11, go to bit 0 of the next channel. After ch5/bit11 → FINISH, otherwise → SEL.
- FINISH: write DPTRAINING bit31=1 (training disabled), pulse done_o, clear busy_o → IDLE.

Other rules:
- cur_bit_o is valid while busy_o=1 and holds its last value otherwise.
- A full run takes about 72 × 32 × (SETTLE_CYCLES+3) cycles, plus slips.

Optional Feature:
- RITC_ALIGN_EYE_LOG_EN defined:
  - A 72x6 register array stores best_len per bit at CENTER (the stored value is best_len even when the bit fails).
  - The array is cleared on start_i and on reset.
  - eye_width_o = array[ch*12+bit] decoded from eye_addr_i, registered (1-cycle latency).
  - Out-of-range addresses (bit>11 or ch>5) read 0.
- Undefined: eye_width_o tied to 0 and eye_addr_i unused.

Decomposition:
- Shared package ritc_align_pkg:
  - register address constants (DPTRAINING=2, DPIDELAY=4);
  - field bit positions (TRAIN_DISABLE=31, BITSLIP=30, SEL_LSB=16, LOAD=31);
  - the state enum typedef;
  - NUM_CH=6 and NUM_BIT=12.
- One sub-module: ritc_eye_tracker, the run-length/best-run tracker with clear, tap, pass, best_start and best_len.

Test Plan:
- Behavioural datapath model, every bit passing taps 10–20 with pattern already exact; pulse start_i → each bit loaded with delay 15, no bitslip writes, fail_map_o=0, single done_o pulse, last write = DPTRAINING 32'h8000_0000 | sel.
- Bit ch2/bit5 passing only taps 3–5 → fail bit 29 set, delay 0 loaded for select 7'h25, all other bits align normally.
- Bit ch0/bit0 with two runs, taps 2–6 and 20–24 → first run chosen, delay 4 loaded.
- Model that requires 3 bitslips to reach 8'hA6 → exactly 3 writes with bit30=1, then pass. A model that never matches → 8 slips, fail bit set.
- rst_i asserted during the SETTLE of bit 40 → all outputs 0 within the same cycle, no further bus activity, and a fresh start_i runs from ch0/bit0.
- With RITC_ALIGN_EYE_LOG_EN and eye taps 10–20: eye_addr_i=7'h13 → eye_width_o=11 one cycle later; eye_addr_i=7'h0C → 0.
